// File: rtl/dnu_signext_writer_if.sv
// dnu_signext_writer_if: valid/ready chunk handshake from the sign-extension stage
interface dnu_signext_writer_if #(
  parameter int DATA_WIDTH = 85
);
  logic [DATA_WIDTH-1:0] sign_in;
  logic                  sign_valid;
  logic                  sign_ready;
  modport master (output sign_in, output sign_valid, input sign_ready);
  modport slave  (input sign_in, input sign_valid, output sign_ready);
endinterface

// File: rtl/dnu_signext_writer.sv
// dnu_signext_writer: write-side sequencer filling the DNU sign-extension buffer RAM one chunk per accept
module dnu_signext_writer #(
  parameter int ROW_CHUNK_NUM     = 9,
  parameter int CHECK_PARALLELISM = 85,
  parameter int DEPTH             = ROW_CHUNK_NUM,
  parameter int DATA_WIDTH        = CHECK_PARALLELISM,
  parameter int ADDR_WIDTH        = $clog2(DEPTH)
) (
  input  logic                  write_clk,
  input  logic                  rstn,
  dnu_signext_writer_if.slave   sif,
  input  logic                  frame_start,
  input  logic                  rd_release,
  output logic [DATA_WIDTH-1:0] signExten_din,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  we,
  output logic                  frame_done,
  output logic                  frame_abort
);
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ROW_CHUNK_NUM - 1);
  state_t                r_state, w_next_state;
  logic [ADDR_WIDTH-1:0] r_cnt, r_addr;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_we, r_done, r_abort;
  logic                  w_fill, w_accept, w_last, w_abort, w_start;
  assign w_fill   = r_state == FILL;
  assign w_abort  = w_fill & frame_start;
  assign w_accept = w_fill & sif.sign_valid & ~frame_start;
  assign w_last   = w_accept & (r_cnt == LAST);
  assign w_start  = frame_start & ((r_state == IDLE) | ((r_state == HOLD) & rd_release));
  assign signExten_din = r_din;
  assign write_addr    = r_addr;
  assign we            = r_we;
  assign frame_done    = r_done;
  assign frame_abort   = r_abort;
  // state register
  always_ff @(posedge write_clk)
    r_state <= !rstn ? IDLE : w_next_state;
  // next state: start arms FILL, last chunk parks in HOLD, release frees (or re-arms with start)
  always_comb
    w_next_state = r_state == IDLE ? (frame_start ? FILL : IDLE) :
                   r_state == FILL ? (w_last ? HOLD : FILL) :
                   rd_release      ? (frame_start ? FILL : IDLE) : HOLD;
  // producer is only ready while filling
  always_comb
    sif.sign_ready = w_fill;
  // chunk counter: cleared on start/abort/wrap, advanced on each kept accept
  always_ff @(posedge write_clk)
    if (!rstn || w_start || w_abort || w_last) r_cnt <= '0;
    else if (w_accept) r_cnt <= r_cnt + 1'b1;
  // registered RAM write port and event pulses
  always_ff @(posedge write_clk)
    if (!rstn) begin
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
    end else begin
      r_we    <= w_accept;
      r_done  <= w_last;
      r_abort <= w_abort;
      if (w_accept) begin
        r_addr <= r_cnt;
        r_din  <= sif.sign_in;
      end
    end
endmodule

// File: tb/tb_dnu_signext_writer.sv
// tb_dnu_signext_writer: scoreboard bench for the sign-extension RAM writer
module tb_dnu_signext_writer;
  localparam int DW = 85;
  localparam int AW = 4;
  typedef struct {
    logic          last;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;
  typedef enum int {M_IDLE, M_FILL, M_HOLD} mst_t;
  logic          write_clk = 1'b0;
  logic          rstn = 1'b0;
  logic          frame_start = 1'b0;
  logic          rd_release = 1'b0;
  logic [DW-1:0] signExten_din;
  logic [AW-1:0] write_addr;
  logic          we, frame_done, frame_abort;
  int            n_chk = 0;
  int            n_err = 0;
  ent_t          q[$];
  mst_t          m_st = M_IDLE;
  int            m_cnt = 0;
  dnu_signext_writer_if #(.DATA_WIDTH(DW)) sif ();
  dnu_signext_writer dut (
    .write_clk(write_clk), .rstn(rstn), .sif(sif.slave),
    .frame_start(frame_start), .rd_release(rd_release),
    .signExten_din(signExten_din), .write_addr(write_addr), .we(we),
    .frame_done(frame_done), .frame_abort(frame_abort)
  );
  always #5 write_clk = ~write_clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction
  // drive one cycle, advance the reference model, then check the control outputs
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic fs, input logic rr);
    logic e_we, e_ab;
    sif.sign_valid = v;
    sif.sign_in = d;
    frame_start = fs;
    rd_release = rr;
    e_we = 1'b0;
    e_ab = 1'b0;
    if (!rstn) begin
      m_st = M_IDLE;
      m_cnt = 0;
    end else if (m_st == M_IDLE) begin
      if (fs) begin m_st = M_FILL; m_cnt = 0; end
    end else if (m_st == M_FILL) begin
      if (fs) begin
        m_cnt = 0;
        e_ab = 1'b1;
      end else if (v) begin
        q.push_back('{last: m_cnt == 8, addr: AW'(m_cnt), data: d});
        e_we = 1'b1;
        if (m_cnt == 8) begin m_cnt = 0; m_st = M_HOLD; end
        else m_cnt++;
      end
    end else if (rr) begin
      m_st = fs ? M_FILL : M_IDLE;
      m_cnt = 0;
    end
    @(posedge write_clk);
    #1;
    chk("sign_ready", sif.sign_ready, m_st == M_FILL);
    chk("we", we, e_we);
    chk("frame_abort", frame_abort, e_ab);
  endtask
  // pop the scoreboard on every write the DUT issues
  always @(negedge write_clk)
    if (we) begin
      if (q.size() == 0) chk("spurious_write", 1'b1, 1'b0);
      else begin
        ent_t e;
        e = q.pop_front();
        chk("write_addr", write_addr, e.addr);
        chk("write_data", signExten_din, e.data);
        chk("frame_done", frame_done, e.last);
      end
    end else chk("frame_done_idle", frame_done, 1'b0);
  initial begin
    sif.sign_valid = 1'b0;
    sif.sign_in = '0;
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, rnd(), 1'b1, 1'b0);
    chk("rst_addr", write_addr, 0);
    chk("rst_din", signExten_din, 0);
    rstn = 1'b1;
    cyc(1'b1, rnd(), 1'b0, 1'b0);
    // full frame, values 1..9 back to back
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
    // hold: valid held high, and a lone frame_start, are ignored
    for (int i = 0; i < 5; i++) cyc(1'b1, rnd(), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    // gappy producer with a stray rd_release mid-fill
    for (int i = 0; i < 18; i++) cyc(i % 2 == 0, rnd(), 1'b0, i == 5);
    cyc(1'b0, '0, 1'b0, 1'b0);
    // simultaneous release and start, then abort after 4 accepts
    cyc(1'b1, rnd(), 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, rnd(), 1'b0, 1'b0);
    cyc(1'b1, rnd(), 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b1, rnd(), 1'b0, 1'b0);
    // reset after 6 accepts, then a fresh frame from address 0
    cyc(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, rnd(), 1'b0, 1'b0);
    rstn = 1'b0;
    cyc(1'b1, rnd(), 1'b0, 1'b0);
    chk("mid_rst_addr", write_addr, 0);
    chk("mid_rst_din", signExten_din, 0);
    rstn = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b1, rnd(), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dnu_signext_writer.md
# dnu_signext_writer

Write-side sequencer for the DNU sign-extension buffer RAM in the layered decoder (765, girth 10, ROW_CHUNK_NUM = 9 chunks of 85 lanes). Accepts one CHECK_PARALLELISM-wide sign-extension vector per cycle over a valid/ready handshake from the sign-extension stage. Drives the RAM write port (data, address, write enable) in write_clk. Blocks the producer once a full frame of ROW_CHUNK_NUM chunks is stored, until the read side releases the buffer.

## Interface
Parameters:
- ROW_CHUNK_NUM, 9, chunks per frame (RAM depth)
- CHECK_PARALLELISM, 85, lanes per chunk (RAM data width)
- DEPTH, ROW_CHUNK_NUM, number of RAM words
- DATA_WIDTH, CHECK_PARALLELISM, width of each chunk
- ADDR_WIDTH, $clog2(DEPTH), RAM address width (4 for the defaults)

Ports (reset rstn, synchronous, active-low; clock write_clk):
- write_clk  in  1  sole clock; all logic on its rising edge
- rstn  in  1  synchronous active-low reset
- sign_in  in  DATA_WIDTH  sign-extension vector of the current chunk
- sign_valid  in  1  sign_in is valid
- sign_ready  out  1  block accepts a chunk this cycle
- frame_start  in  1  single-cycle pulse; arms a new frame at address 0
- rd_release  in  1  single-cycle pulse from the read side, already in the write_clk domain; frees the buffer
- signExten_din  out  DATA_WIDTH  RAM write data (registered)
- write_addr  out  ADDR_WIDTH  RAM write address (registered)
- we  out  1  RAM write enable (registered)
- frame_done  out  1  single-cycle pulse, coincident with the write of the last chunk
- frame_abort  out  1  single-cycle pulse when a frame in FILL is restarted

## Operation
- States: IDLE, FILL, HOLD. Reset enters IDLE.
- IDLE:
  - sign_ready = 0.
  - frame_start moves to FILL and sets chunk counter cnt = 0.
- FILL:
  - sign_ready = 1, decoded combinationally from state.
  - An accept is sign_valid & sign_ready at a rising edge.
  - On each accept, the next cycle has we = 1, write_addr = cnt, signExten_din = sign_in. The data is passed through unmodified and cnt increments.
  - The accept with cnt == ROW_CHUNK_NUM-1 is the last chunk: cnt wraps to 0, the state moves to HOLD, and frame_done pulses together with that write.
- HOLD:
  - sign_ready = 0.
  - rd_release moves to IDLE.
  - rd_release and frame_start in the same cycle move directly to FILL with cnt = 0.
  - frame_start alone in HOLD is ignored.
- frame_start during FILL:
  - Restarts the frame: cnt = 0, frame_abort pulses next cycle, and the state stays FILL.
  - A chunk accepted in that same cycle is discarded: no we and no cnt increment.
- rd_release outside HOLD is ignored.
- sign_valid outside FILL is ignored: no write, and the producer must hold the data.
- cnt never exceeds ROW_CHUNK_NUM-1. write_addr is always in the range 0..DEPTH-1.
- Reset mid-frame:
  - Returns to IDLE, clears cnt, and deasserts all outputs the next cycle.
  - A write already registered is not issued.

## Timing
- Reset values:
  - sign_ready = 0, we = 0, frame_done = 0, frame_abort = 0.
  - write_addr = 0, signExten_din = 0, state = IDLE, cnt = 0.
- frame_start at edge N → sign_ready = 1 from cycle N+1.
- Accept at edge N → we/write_addr/signExten_din valid in cycle N+1, written by the RAM at edge N+1.
- Throughput is 1 chunk per cycle. A full frame takes ROW_CHUNK_NUM accepting edges.
- The last accept at edge N sets sign_ready = 0 in cycle N+1, with frame_done = 1 and we = 1 in the same cycle N+1.
- rd_release at edge M in HOLD gives IDLE at M+1. Combined with frame_start, sign_ready = 1 at M+1.
- we, frame_done and frame_abort are high for exactly one cycle per event. we may stay high on consecutive cycles during back-to-back accepts.

## Test plan
- **Full frame:** reset, frame_start, then 9 back-to-back valid chunks with values 0x1 to 0x9 → we high for 9 cycles; write_addr 0..8 with matching data; frame_done only on addr 8; sign_ready low afterwards.
- **Gappy producer:** sign_valid toggled 1/0 across the frame → write_addr increments only on accepts; addresses 0..8 have no gaps or duplicates; frame_done on the 9th accept.
- **Hold/release:** after frame_done, hold sign_valid = 1 for 5 cycles → no we. Pulse rd_release then frame_start → next 9 chunks are written to 0..8 again.
- **Simultaneous release and start:** in HOLD, pulse rd_release and frame_start in the same cycle → sign_ready = 1 on the next cycle and cnt = 0.
- **Abort:** frame_start after 4 accepts, coincident with a 5th valid chunk → that chunk is not written; frame_abort pulses; the next accept writes addr 0.
- **Reset mid-frame:** rstn low after 6 accepts → the next cycle has we = 0, sign_ready = 0, write_addr = 0. A new frame_start restarts at addr 0.
